// File: rtl/fifo_rst_seq.sv
// fifo_rst_seq: multi-channel FIFO reset sequencer (IDLE -> CLEAR -> RESET -> PAUSE -> RUN).
// Optional macro FIFO_RST_STAGGER_EN staggers each channel's reset by its channel index.
module fifo_rst_seq #(
   parameter int NCH       = 7,
   parameter int CLR_CYC   = 6,
   parameter int RST_CYC   = 10,
   parameter int PAUSE_CYC = 16
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           AL_RESTART,
   input  logic [NCH-1:0] CH_EN,
   output logic [NCH-1:0] FIFO_RST,
   output logic           DONE,
   output logic           BUSY,
   output logic [7:0]     SEQ_CNT
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RESET = 3'd2,
      ST_PAUSE = 3'd3,
      ST_RUN   = 3'd4
   } state_t;

`ifdef FIFO_RST_STAGGER_EN
   localparam int RST_LEN = RST_CYC + NCH - 1;
`else
   localparam int RST_LEN = RST_CYC;
`endif

   localparam logic [15:0] CLR_LAST   = 16'(CLR_CYC - 1);
   localparam logic [15:0] RST_LAST   = 16'(RST_LEN - 1);
   localparam logic [15:0] PAUSE_LAST = 16'(PAUSE_CYC - 1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [15:0]      hold_r;
   logic [15:0]      hold_nxt_s;
   logic [NCH-1:0]   mask_r;
   logic [NCH-1:0]   mask_nxt_s;
   logic [NCH-1:0]   win_s;
   logic [NCH-1:0]   fifo_rst_nxt_s;
   logic             done_nxt_s;
   logic             busy_nxt_s;
   logic [7:0]       seq_cnt_nxt_s;
   logic             restart_s;
   logic             clr_entry_s;

   // Next-state and phase counter; a restart request overrides normal phase progress.
   always_comb begin
      state_nxt_s = state_r;
      hold_nxt_s  = hold_r + 16'd1;
      restart_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            state_nxt_s = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (AL_RESTART) begin
               restart_s = 1'b1;
            end else if (hold_r == CLR_LAST) begin
               state_nxt_s = ST_RESET;
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         ST_RESET: begin
            if (AL_RESTART) begin
               restart_s   = 1'b1;
               state_nxt_s = ST_CLEAR;
            end else if (hold_r == RST_LAST) begin
               state_nxt_s = ST_PAUSE;
            end else begin
               state_nxt_s = ST_RESET;
            end
         end
         ST_PAUSE: begin
            if (AL_RESTART) begin
               restart_s   = 1'b1;
               state_nxt_s = ST_CLEAR;
            end else if (hold_r == PAUSE_LAST) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_PAUSE;
            end
         end
         ST_RUN: begin
            hold_nxt_s = hold_r;
            if (AL_RESTART) begin
               restart_s   = 1'b1;
               state_nxt_s = ST_CLEAR;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      if ((state_nxt_s != state_r) || restart_s) begin
         hold_nxt_s = 16'd0;
      end else begin
         hold_nxt_s = hold_nxt_s;
      end
   end

   // Channel window inside RESET: all channels at once, or shifted by channel index.
   always_comb begin
      win_s = {NCH{1'b0}};
`ifdef FIFO_RST_STAGGER_EN
      for (int i = 0; i < NCH; i++) begin
         win_s[i] = ({1'b0, hold_nxt_s} >= 17'(i)) &&
                    ({1'b0, hold_nxt_s} <  17'(i + RST_CYC));
      end
`else
      win_s = {NCH{1'b1}};
`endif
   end

   // Output values for the state being entered, so every output comes straight from a flop.
   always_comb begin
      clr_entry_s    = (state_nxt_s == ST_CLEAR) && ((state_r != ST_CLEAR) || restart_s);
      mask_nxt_s     = clr_entry_s ? CH_EN : mask_r;
      fifo_rst_nxt_s = {NCH{1'b0}};
      done_nxt_s     = 1'b0;
      busy_nxt_s     = 1'b1;
      case (state_nxt_s)
         ST_IDLE:  fifo_rst_nxt_s = {NCH{1'b1}};
         ST_RESET: fifo_rst_nxt_s = mask_nxt_s & win_s;
         ST_RUN: begin
            done_nxt_s = 1'b1;
            busy_nxt_s = 1'b0;
         end
         default: begin
            fifo_rst_nxt_s = {NCH{1'b0}};
         end
      endcase
      if ((state_nxt_s == ST_RUN) && (state_r != ST_RUN) && (SEQ_CNT != 8'hFF)) begin
         seq_cnt_nxt_s = SEQ_CNT + 8'd1;
      end else begin
         seq_cnt_nxt_s = SEQ_CNT;
      end
   end

   // State, counter, latched mask and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r  <= ST_IDLE;
         hold_r   <= 16'd0;
         mask_r   <= {NCH{1'b1}};
         FIFO_RST <= {NCH{1'b1}};
         DONE     <= 1'b0;
         BUSY     <= 1'b1;
         SEQ_CNT  <= 8'd0;
      end else begin
         state_r  <= state_nxt_s;
         hold_r   <= hold_nxt_s;
         mask_r   <= mask_nxt_s;
         FIFO_RST <= fifo_rst_nxt_s;
         DONE     <= done_nxt_s;
         BUSY     <= busy_nxt_s;
         SEQ_CNT  <= seq_cnt_nxt_s;
      end
   end

endmodule

// File: tb/tb_fifo_rst_seq.sv
// tb_fifo_rst_seq: directed and randomized stimulus against an edge-timeline reference model.
// The model tracks the edge index since the last CLEAR entry and derives outputs from it.
module tb_fifo_rst_seq;

   localparam int NCH       = 7;
   localparam int CLR_CYC   = 6;
   localparam int RST_CYC   = 10;
   localparam int PAUSE_CYC = 16;
`ifdef FIFO_RST_STAGGER_EN
   localparam int STAG = 1;
`else
   localparam int STAG = 0;
`endif
   localparam int N = CLR_CYC + RST_CYC + STAG * (NCH - 1) + PAUSE_CYC;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic           AL_RESTART = 1'b0;
   logic [NCH-1:0] CH_EN = {NCH{1'b1}};
   logic [NCH-1:0] FIFO_RST;
   logic           DONE;
   logic           BUSY;
   logic [7:0]     SEQ_CNT;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: m_e = -1 in IDLE, else edges since CLEAR entry (saturates at N = RUN).
   int             m_e    = -1;
   logic [NCH-1:0] m_mask = {NCH{1'b1}};
   int             m_cnt  = 0;

   fifo_rst_seq #(
      .NCH(NCH), .CLR_CYC(CLR_CYC), .RST_CYC(RST_CYC), .PAUSE_CYC(PAUSE_CYC)
   ) dut (
      .CLK(CLK), .RST(RST), .AL_RESTART(AL_RESTART), .CH_EN(CH_EN),
      .FIFO_RST(FIFO_RST), .DONE(DONE), .BUSY(BUSY), .SEQ_CNT(SEQ_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t, model edge %0d)", tag, got, exp, $time, m_e);
      end
   endtask

   task automatic model_edge(input logic rst, input logic rs, input logic [NCH-1:0] en);
      int prev;
      prev = m_e;
      if (rst) begin
         m_e    = -1;
         m_mask = {NCH{1'b1}};
         m_cnt  = 0;
      end else if (m_e < 0 || rs) begin
         m_e    = 0;
         m_mask = en;
      end else if (m_e < N) begin
         m_e++;
      end
      if (!rst && m_e == N && prev == N - 1 && m_cnt < 255) m_cnt++;
   endtask

   function automatic logic [NCH-1:0] exp_fifo();
      logic [NCH-1:0] v;
      int lo;
      v = {NCH{1'b0}};
      if (m_e < 0) begin
         v = {NCH{1'b1}};
      end else begin
         for (int i = 0; i < NCH; i++) begin
            lo = CLR_CYC + STAG * i;
            v[i] = m_mask[i] && (m_e >= lo) && (m_e <= lo + RST_CYC - 1);
         end
      end
      return v;
   endfunction

   task automatic step(input logic rst, input logic rs, input logic [NCH-1:0] en);
      @(negedge CLK);
      RST        = rst;
      AL_RESTART = rs;
      CH_EN      = en;
      @(posedge CLK);
      model_edge(rst, rs, en);
      #1;
      chk("fifo_rst", 32'(FIFO_RST), 32'(exp_fifo()));
      chk("done",     32'(DONE),     32'(m_e == N));
      chk("busy",     32'(BUSY),     32'(m_e != N));
      chk("seq_cnt",  32'(SEQ_CNT),  32'(m_cnt));
   endtask

   initial begin
      int lat;
      logic [NCH-1:0] en;

      repeat (3) step(1'b1, 1'b0, 7'h7F);

      // Full sequence with all channels; measure DONE edge index.
      lat = -1;
      for (int k = 0; k < N + 6; k++) begin
         step(1'b0, 1'b0, 7'h7F);
         if (DONE && lat < 0) lat = k;
      end
      chk("done_edge", 32'(lat), 32'(N));

      // Mask 05 latched at CLEAR entry, CH_EN changed mid-sequence.
      step(1'b0, 1'b1, 7'h05);
      for (int k = 1; k < N + 4; k++) step(1'b0, 1'b0, (k >= 3) ? 7'h7F : 7'h05);

      // Restart mid-RESET at edge 10.
      step(1'b0, 1'b1, 7'h7F);
      for (int k = 1; k < 10; k++) step(1'b0, 1'b0, 7'h7F);
      step(1'b0, 1'b1, 7'h3C);
      for (int k = 0; k < N + 4; k++) step(1'b0, 1'b0, 7'h11);

      // Zero mask still completes and counts.
      step(1'b0, 1'b1, 7'h00);
      for (int k = 1; k < N + 3; k++) step(1'b0, 1'b0, 7'h7F);

      // RST asserted during PAUSE, then full sequence again.
      step(1'b0, 1'b1, 7'h7F);
      for (int k = 1; k < 20; k++) step(1'b0, 1'b0, 7'h7F);
      step(1'b1, 1'b0, 7'h00);
      for (int k = 0; k < N + 3; k++) step(1'b0, 1'b0, 7'h2A);

      // Randomized restarts, resets and mask changes.
      for (int k = 0; k < 3000; k++) begin
         en = NCH'($urandom);
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0), en);
      end

      // Drive enough complete sequences to reach SEQ_CNT saturation.
      for (int s = 0; s < 260; s++) begin
         en = NCH'($urandom);
         step(1'b0, 1'b1, en);
         for (int k = 0; k < N; k++) step(1'b0, 1'b0, en);
      end
      chk("seq_cnt_sat", 32'(SEQ_CNT), 32'd255);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
